// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package dmem_arb_pkg;

  // Access sequencer: IDLE picks a request, SERVE drives the memory for one cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  // Index of a requesting port.
  typedef logic port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-request round-robin pick: a lone request wins, a tie goes to the port not served last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
// Ports: req0/req1 requests, last = port served most recently,
//        any_req = at least one request, winner = chosen port.
import dmem_arb_pkg::*;

module rr_arbiter_2 (
  input  logic  req0,
  input  logic  req1,
  input  port_t last,
  output logic  any_req,
  output port_t winner
);

  always_comb begin
    any_req = req0 | req1;
    winner  = PORT0;
    if (req0 && req1) begin
      winner = (last == PORT0) ? PORT1 : PORT0;
    end else if (req1) begin
      winner = PORT1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one single-port data memory, at most one access per 2 cycles.
// Latency: request seen in IDLE -> gnt next cycle -> rvalid (reads) the cycle after that.
// Backpressure: requester holds req and fields until its gnt pulse; no request queueing.
// Ports: clk, rst_n (synchronous, active-high despite the name);
//        port N: reqN/weN/addrN/wdataN in, gntN/rvalidN out; shared registered rdata;
//        busy = SERVE; memory side: mem_R_W/mem_select/mem_d out, mem_q in (combinational).
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int Bits    = 8,
  parameter int SelBits = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [SelBits-1:0] addr0,
  input  logic [SelBits-1:0] addr1,
  input  logic [Bits-1:0]    wdata0,
  input  logic [Bits-1:0]    wdata1,
  output logic               gnt0,
  output logic               gnt1,
  output logic [Bits-1:0]    rdata,
  output logic               rvalid0,
  output logic               rvalid1,
  output logic               busy,
  output logic               mem_R_W,
  output logic [SelBits-1:0] mem_select,
  output logic [Bits-1:0]    mem_d,
  input  logic [Bits-1:0]    mem_q
);

  state_e               state_q;
  state_e               state_d;
  port_t                last_q;      // port captured most recently; also the port being served
  logic                 cap_we_q;
  logic [SelBits-1:0]   cap_addr_q;
  logic [Bits-1:0]      cap_wdata_q;
  logic                 any_req;
  port_t                winner;
  logic                 take;

  rr_arbiter_2 u_rr (
    .req0    (req0),
    .req1    (req1),
    .last    (last_q),
    .any_req (any_req),
    .winner  (winner)
  );

  assign take = (state_q == IDLE) && any_req;

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: SERVE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = SERVE;
      SERVE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Select and write data simply follow the capture registers, so they
  // hold the last access outside SERVE; only the write strobe is qualified.
  always_comb begin
    busy       = (state_q == SERVE);
    gnt0       = busy && (last_q == PORT0);
    gnt1       = busy && (last_q == PORT1);
    // Reset kills a write still sitting in SERVE so it never commits.
    mem_R_W    = busy && cap_we_q && !rst_n;
    mem_select = cap_addr_q;
    mem_d      = cap_wdata_q;
  end

  // Capture the winner's access. Reset leaves the pointer on port 1 so port 0
  // wins the first tie.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      last_q      <= PORT1;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else if (take) begin
      last_q      <= winner;
      cap_we_q    <= (winner == PORT1) ? we1 : we0;
      cap_addr_q  <= (winner == PORT1) ? addr1 : addr0;
      cap_wdata_q <= (winner == PORT1) ? wdata1 : wdata0;
    end
  end

  // Read return: memory data sampled at the end of SERVE, rvalid one cycle later.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rdata   <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if ((state_q == SERVE) && !cap_we_q) begin
        rdata   <= mem_q;
        rvalid0 <= (last_q == PORT0);
        rvalid1 <= (last_q == PORT1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a transaction-level scheduling model with its own reference memory.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dmem_arbiter;

  localparam int NR = 300;

  logic       clk;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, mem_R_W;
  logic [7:0] rdata, mem_d, mem_q;
  logic [2:0] mem_select;

  logic       pre_we;
  logic [2:0] pre_addr;
  logic [7:0] pre_dat;
  logic [7:0] tmem [0:7];

  int checks   = 0;
  int failures = 0;
  int run_len  = 0;
  int max_run  = 0;

  dmem_arbiter #(.Bits(8), .SelBits(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rdata      (rdata),
    .rvalid0    (rvalid0),
    .rvalid1    (rvalid1),
    .busy       (busy),
    .mem_R_W    (mem_R_W),
    .mem_select (mem_select),
    .mem_d      (mem_d),
    .mem_q      (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the arbiter, with a private preload port.
  always @(posedge clk) begin
    if (pre_we) tmem[pre_addr] <= pre_dat;
    else if (mem_R_W) tmem[mem_select] <= mem_d;
  end
  assign mem_q = tmem[mem_select];

  // Longest run of consecutive mem_R_W cycles.
  always @(negedge clk) begin
    if (mem_R_W) begin
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin failures++; $display("FAIL rst_gnt got=%b%b exp=00", gnt0, gnt1); end
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b%b exp=00", rvalid0, rvalid1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
    checks++; if (mem_R_W !== 1'b0) begin failures++; $display("FAIL rst_mem_R_W got=%b exp=0", mem_R_W); end
    checks++; if (mem_select !== 3'd0 || mem_d !== 8'h00) begin failures++; $display("FAIL rst_memio got sel=%0d d=%h exp sel=0 d=00", mem_select, mem_d); end
    rst_n = 1'b0;
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd5; wdata0 = 8'hA5;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin failures++; $display("FAIL wr_gnt got=%b%b exp=10", gnt0, gnt1); end
    checks++; if (busy !== 1'b1 || mem_R_W !== 1'b1) begin failures++; $display("FAIL wr_strobe got busy=%b rw=%b exp 1 1", busy, mem_R_W); end
    checks++; if (mem_select !== 3'd5 || mem_d !== 8'hA5) begin failures++; $display("FAIL wr_memio got sel=%0d d=%h exp sel=5 d=a5", mem_select, mem_d); end
    req0 = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || mem_R_W !== 1'b0 || gnt0 !== 1'b0) begin failures++; $display("FAIL wr_idle got busy=%b rw=%b gnt0=%b exp 0 0 0", busy, mem_R_W, gnt0); end
    checks++; if (mem_select !== 3'd5 || tmem[5] !== 8'hA5) begin failures++; $display("FAIL wr_commit got sel=%0d mem5=%h exp sel=5 mem5=a5", mem_select, tmem[5]); end
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd5;
    @(negedge clk);
    checks++; if (gnt0 !== 1'b1 || mem_R_W !== 1'b0) begin failures++; $display("FAIL rd_gnt got gnt0=%b rw=%b exp 1 0", gnt0, mem_R_W); end
    req0 = 1'b0;
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin failures++; $display("FAIL rd_rvalid got=%b%b exp=10", rvalid0, rvalid1); end
    checks++; if (rdata !== 8'hA5) begin failures++; $display("FAIL rd_rdata got=%h exp=a5", rdata); end
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b0 || rdata !== 8'hA5) begin failures++; $display("FAIL rd_hold got rvalid0=%b rdata=%h exp 0 a5", rvalid0, rdata); end
  endtask

  task automatic test_alternate();
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd2;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++; if (gnt0 !== (k % 4 == 1) || gnt1 !== (k % 4 == 3)) begin failures++; $display("FAIL alt_gnt cyc=%0d got=%b%b exp=%b%b", k, gnt0, gnt1, (k % 4 == 1), (k % 4 == 3)); end
      checks++; if (rvalid0 !== (k % 4 == 2) || rvalid1 !== (k % 4 == 0)) begin failures++; $display("FAIL alt_rvalid cyc=%0d got=%b%b exp=%b%b", k, rvalid0, rvalid1, (k % 4 == 2), (k % 4 == 0)); end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_port1_reads();
    preload(3'd0, 8'h10);
    preload(3'd1, 8'h11);
    preload(3'd2, 8'h12);
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++; if (gnt1 !== k[0] || gnt0 !== 1'b0) begin failures++; $display("FAIL p1_gnt cyc=%0d got=%b%b exp=0%b", k, gnt0, gnt1, k[0]); end
      checks++; if (rvalid1 !== !k[0] || rvalid0 !== 1'b0) begin failures++; $display("FAIL p1_rvalid cyc=%0d got=%b%b exp=0%b", k, rvalid0, rvalid1, !k[0]); end
      if (!k[0]) begin
        checks++; if (rdata !== 8'(8'h10 + k / 2 - 1)) begin failures++; $display("FAIL p1_rdata cyc=%0d got=%h exp=%h", k, rdata, 8'(8'h10 + k / 2 - 1)); end
      end
      if (k[0]) begin
        if (k < 5) addr1 = 3'((k + 1) / 2);
        else req1 = 1'b0;
      end
    end
  endtask

  task automatic test_reset_in_serve();
    preload(3'd3, 8'h00);
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd3; wdata0 = 8'hFF;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || gnt0 !== 1'b1) begin failures++; $display("FAIL rsv_serve got busy=%b gnt0=%b exp 1 1", busy, gnt0); end
    rst_n = 1'b1; req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    checks++; if (busy !== 1'b0 || mem_R_W !== 1'b0) begin failures++; $display("FAIL rsv_idle got busy=%b rw=%b exp 0 0", busy, mem_R_W); end
    checks++; if (tmem[3] !== 8'h00) begin failures++; $display("FAIL rsv_nocommit got mem3=%h exp=00", tmem[3]); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin failures++; $display("FAIL rsv_nognt cyc=%0d got=%b%b exp=00", k, gnt0, gnt1); end
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd3;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    checks++; if (rvalid0 !== 1'b1 || rdata !== 8'h00) begin failures++; $display("FAIL rsv_read got rvalid0=%b rdata=%h exp 1 00", rvalid0, rdata); end
  endtask

  task automatic test_abandon();
    preload(3'd6, 8'h11);
    preload(3'd7, 8'h00);
    // Port 0 served last, so port 1 wins the coming tie.
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd0;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd6; wdata0 = 8'h5A;
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd7; wdata1 = 8'h3C;
    @(negedge clk);
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin failures++; $display("FAIL ab_gnt got=%b%b exp=01", gnt0, gnt1); end
    checks++; if (mem_select !== 3'd7 || mem_R_W !== 1'b1) begin failures++; $display("FAIL ab_memio got sel=%0d rw=%b exp 7 1", mem_select, mem_R_W); end
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_R_W !== 1'b0) begin failures++; $display("FAIL ab_quiet cyc=%0d got gnt=%b%b rw=%b exp 00 0", k, gnt0, gnt1, mem_R_W); end
    end
    checks++; if (tmem[6] !== 8'h11 || tmem[7] !== 8'h3C) begin failures++; $display("FAIL ab_mem got m6=%h m7=%h exp 11 3c", tmem[6], tmem[7]); end
    checks++; if (max_run > 1) begin failures++; $display("FAIL ab_pulse got max_run=%0d exp<=1", max_run); end
  endtask

  task automatic test_random();
    logic [7:0] refmem [0:7];
    bit         eg0 [0:NR+3];
    bit         eg1 [0:NR+3];
    bit         ev0 [0:NR+3];
    bit         ev1 [0:NR+3];
    bit         ew  [0:NR+3];
    logic [7:0] ed  [0:NR+3];
    bit         act [2];
    bit         fwe [2];
    logic [2:0] fad [2];
    logic [7:0] fwd [2];
    bit         granted;
    int         mlast, next_free, w;
    logic [7:0] cur;
    do_reset();
    for (int a = 0; a < 8; a++) begin
      refmem[a] = 8'($urandom);
      preload(3'(a), refmem[a]);
    end
    for (int i = 0; i <= NR + 3; i++) begin
      eg0[i] = 0; eg1[i] = 0; ev0[i] = 0; ev1[i] = 0; ew[i] = 0; ed[i] = 8'h00;
    end
    act[0] = 0; act[1] = 0;
    mlast = 1; next_free = 0; cur = 8'h00;
    for (int c = 0; c < NR; c++) begin
      @(negedge clk);
      if (ev0[c] || ev1[c]) cur = ed[c];
      checks++; if (gnt0 !== eg0[c] || gnt1 !== eg1[c]) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b%b exp=%b%b", c, gnt0, gnt1, eg0[c], eg1[c]); end
      checks++; if (rvalid0 !== ev0[c] || rvalid1 !== ev1[c]) begin failures++; $display("FAIL rnd_rvalid cyc=%0d got=%b%b exp=%b%b", c, rvalid0, rvalid1, ev0[c], ev1[c]); end
      checks++; if (rdata !== cur) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, rdata, cur); end
      checks++; if (busy !== (eg0[c] | eg1[c]) || mem_R_W !== ew[c]) begin failures++; $display("FAIL rnd_busy cyc=%0d got busy=%b rw=%b exp %b %b", c, busy, mem_R_W, eg0[c] | eg1[c], ew[c]); end
      // Requester behaviour.
      for (int p = 0; p < 2; p++) begin
        granted = (p == 0) ? eg0[c] : eg1[c];
        if (granted) begin
          if (c >= NR - 6 || $urandom_range(1, 0) == 0) act[p] = 0;
        end else if (act[p]) begin
          if (c >= NR - 6 || $urandom_range(99, 0) < 5) act[p] = 0;
        end else if (c < NR - 6 && $urandom_range(99, 0) < 40) begin
          act[p] = 1; fwe[p] = $urandom_range(1, 0) == 1;
          fad[p] = 3'($urandom); fwd[p] = 8'($urandom);
        end
      end
      req0 = act[0]; we0 = fwe[0]; addr0 = fad[0]; wdata0 = fwd[0];
      req1 = act[1]; we1 = fwe[1]; addr1 = fad[1]; wdata1 = fwd[1];
      // Scheduling model: when free, pick by round robin; the access occupies two cycles.
      if (c >= next_free && (act[0] || act[1])) begin
        if (act[0] && act[1]) w = 1 - mlast;
        else w = act[0] ? 0 : 1;
        mlast = w;
        if (w == 0) eg0[c+1] = 1; else eg1[c+1] = 1;
        if (fwe[w]) begin
          ew[c+1] = 1;
          refmem[fad[w]] = fwd[w];
        end else begin
          if (w == 0) ev0[c+2] = 1; else ev1[c+2] = 1;
          ed[c+2] = refmem[fad[w]];
        end
        next_free = c + 2;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (max_run > 1) begin failures++; $display("FAIL rnd_pulse got max_run=%0d exp<=1", max_run); end
  endtask

  initial begin
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 3'd0; addr1 = 3'd0; wdata0 = 8'h00; wdata1 = 8'h00;
    pre_we = 1'b0; pre_addr = 3'd0; pre_dat = 8'h00;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_alternate();
    test_port1_reads();
    test_reset_in_serve();
    test_abandon();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter Bits, default 8, data word width.
REQ-002 Parameter SelBits, default 3, memory select (address) width; memory depth 2**SelBits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-high.
REQ-005 req0 / req1  input  1  access request from port 0 (processor) / port 1 (I/O or debug).
REQ-006 we0 / we1  input  1  1 = write, 0 = read; valid while reqN high.
REQ-007 addr0 / addr1  input  SelBits  memory select for the access.
REQ-008 wdata0 / wdata1  input  Bits  write data.
REQ-009 gnt0 / gnt1  output  1  one-cycle pulse: access of that port executes this cycle.
REQ-010 rdata  output  Bits  registered read data, shared by both ports.
REQ-011 rvalid0 / rvalid1  output  1  one-cycle pulse: rdata holds that port's read result.
REQ-012 busy  output  1  high while state is SERVE.
REQ-013 mem_R_W  output  1  write enable to memory (1 = write).
REQ-014 mem_select  output  SelBits  memory select.
REQ-015 mem_d  output  Bits  memory write data.
REQ-016 mem_q  input  Bits  memory read data, combinational from mem_select.

Function
REQ-017 FSM states IDLE, SERVE; SERVE always returns to IDLE, giving one access per 2 cycles max.
REQ-018 IDLE: if req0 or req1, pick winner, capture its we/addr/wdata into registers, record winner, go SERVE; else stay IDLE.
REQ-019 Arbitration round-robin: single request wins; both requesting -> port not served last wins; last-served pointer updates on every IDLE->SERVE.
REQ-020 SERVE: mem_select = captured addr, mem_d = captured wdata, mem_R_W = captured we; gnt of winner high for exactly this cycle.
REQ-021 Outside SERVE: mem_R_W = 0, mem_select and mem_d hold last captured values.
REQ-022 Read in SERVE: mem_q sampled at end of SERVE into rdata; rvalid of winner pulses the following cycle (2 cycles after request seen in IDLE).
REQ-023 Write: no rvalid; memory updated at the SERVE clock edge; read of same address in next access returns new data.
REQ-024 Requester holds reqN and fields stable until gntN; may drop or re-raise reqN the cycle after gntN.
REQ-025 Request still high in the cycle after SERVE is treated as a new request (back-to-back allowed); with both ports continuously requesting, grants alternate 0,1,0,1.
REQ-026 rdata holds value until next read completes; rvalid0 and rvalid1 never high together; gnt0 and gnt1 never high together.
REQ-027 Request dropped before grant is abandoned with no memory access.

Reset
REQ-028 rst_n high at a clock edge: state IDLE, pointer favours port 0, captured regs 0, rdata 0, all gnt/rvalid/busy 0.
REQ-029 mem_R_W gated low whenever rst_n is high, so an in-flight SERVE write in the reset cycle does not commit; in-flight read gives no rvalid.

Structure
REQ-030 Package dmem_arb_pkg holds state enum (IDLE, SERVE) and port-index typedef.
REQ-031 Sub-module rr_arbiter_2: combinational two-request round-robin pick from req0, req1, last pointer; FSM and registers stay in dmem_arbiter.

Verification
REQ-032 Write then read: req0 we=1 addr=5 wdata=8'hA5, then read addr=5 -> gnt0 per access, rvalid0 with rdata=8'hA5.
REQ-033 Simultaneous: req0 and req1 high together from reset, both held -> gnt0 first, then gnt1, alternation continues 0,1,0,1.
REQ-034 Port 1 only, three reads addr 0,1,2 preloaded 8'h10,8'h11,8'h12 -> rvalid1 every 2 cycles, rdata 8'h10,8'h11,8'h12.
REQ-035 Reset during SERVE of write addr=3 wdata=8'hFF (addr 3 held 8'h00) -> no gnt afterwards, later read addr 3 returns 8'h00.
REQ-036 req0 dropped in the cycle req1 wins -> only gnt1, no port-0 access, mem_R_W pulses never exceed 1 cycle.
